// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port register file between writeback and decode.
//   - Two write ports; port 1 wins when both target the same register.
//   - Two combinational read ports with same-cycle write-to-read bypass.
//   - Register TAP_REG is driven continuously on data_tap (stored value only).
//   - A bulk-clear sweep engine zeroes one register per cycle after a
//     ctrl_clear pulse, so the file can be cleared without asserting reset.
//
// Ports:
//   clock          in   sole clock, rising edge
//   ctrl_reset     in   synchronous active-low reset
//   ctrl_we0       in   write enable, port 0
//   ctrl_waddr0    in   write address, port 0
//   data_w0        in   write data, port 0
//   ctrl_we1       in   write enable, port 1 (priority port)
//   ctrl_waddr1    in   write address, port 1
//   data_w1        in   write data, port 1
//   ctrl_readRegA  in   read address A
//   ctrl_readRegB  in   read address B
//   data_readRegA  out  read data A (combinational)
//   data_readRegB  out  read data B (combinational)
//   data_tap       out  stored value of register TAP_REG
//   ctrl_clear     in   single-cycle pulse, starts a clear sweep
//   clear_busy     out  high while a sweep is in progress
//   wr_dropped     out  registered; high one cycle after a write was discarded
//   dbg_state      out  current FSM state (0 = IDLE, 1 = SWEEP)
//
// Handshake: there is no valid/ready pairing here. A write is presented by
// holding we/waddr/data stable across one rising edge; it is committed at
// that edge when the FSM is IDLE, or discarded (and flagged on wr_dropped
// the next cycle) when the FSM is in SWEEP. ctrl_clear is a level sampled
// at the edge and only acted on in IDLE.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int TAP_REG   = 10,
    parameter int ZERO_REG0 = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_we0,
    input  logic [ADDR_W-1:0] ctrl_waddr0,
    input  logic [DATA_W-1:0] data_w0,
    input  logic              ctrl_we1,
    input  logic [ADDR_W-1:0] ctrl_waddr1,
    input  logic [DATA_W-1:0] data_w1,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic [DATA_W-1:0] data_tap,
    input  logic              ctrl_clear,
    output logic              clear_busy,
    output logic              wr_dropped,
    output logic              dbg_state
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam bit                ZERO_EN = (ZERO_REG0 != 0);
    localparam logic [ADDR_W-1:0] TAP_IDX = ADDR_W'(TAP_REG);
    localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wr_dropped;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_we0_eff;
    logic              w_we1_eff;
    logic              w_idle;
    logic              w_any_wr;

    // Effective write enables. Port 0 loses to port 1 on an address match;
    // register 0 writes vanish when it is hardwired to zero. These same
    // masked enables decide what counts as a dropped write during a sweep.
    always_comb begin
        w_we1_eff = ctrl_we1 && !(ZERO_EN && (ctrl_waddr1 == '0));
        w_we0_eff = ctrl_we0
                    && !(ZERO_EN && (ctrl_waddr0 == '0))
                    && !(ctrl_we1 && (ctrl_waddr1 == ctrl_waddr0));
        w_any_wr  = w_we0_eff || w_we1_eff;
        w_idle    = (r_state == ST_IDLE);
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_clear) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                // ctrl_clear is ignored here, so a sweep never restarts.
                if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        clear_busy = (r_state == ST_SWEEP);
        dbg_state  = r_state;
        wr_dropped = r_wr_dropped;
    end

    // ---------------------------------------------------------------------
    // Sweep counter and dropped-write flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            r_cnt        <= '0;
            r_wr_dropped <= 1'b0;
        end else begin
            // Natural wrap returns the counter to 0 as the sweep ends.
            if (r_state == ST_SWEEP) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_wr_dropped <= (r_state == ST_SWEEP) && w_any_wr;
        end
    end

    // ---------------------------------------------------------------------
    // Storage. Writes commit only in IDLE (including the cycle ctrl_clear
    // is seen); in SWEEP the only update is zeroing register[cnt].
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_IDLE) begin
            if (w_we0_eff) begin
                r_mem[ctrl_waddr0] <= data_w0;
            end
            if (w_we1_eff) begin
                r_mem[ctrl_waddr1] <= data_w1;
            end
        end else begin
            r_mem[r_cnt] <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Read ports. Bypass is only active in IDLE; during a sweep the reads
    // reflect the partially cleared stored contents.
    // ---------------------------------------------------------------------
    always_comb begin
        if (ZERO_EN && (ctrl_readRegA == '0)) begin
            data_readRegA = '0;
        end else if (w_idle && ctrl_we1 && (ctrl_waddr1 == ctrl_readRegA)) begin
            data_readRegA = data_w1;
        end else if (w_idle && ctrl_we0 && (ctrl_waddr0 == ctrl_readRegA)) begin
            data_readRegA = data_w0;
        end else begin
            data_readRegA = r_mem[ctrl_readRegA];
        end

        if (ZERO_EN && (ctrl_readRegB == '0)) begin
            data_readRegB = '0;
        end else if (w_idle && ctrl_we1 && (ctrl_waddr1 == ctrl_readRegB)) begin
            data_readRegB = data_w1;
        end else if (w_idle && ctrl_we0 && (ctrl_waddr0 == ctrl_readRegB)) begin
            data_readRegB = data_w0;
        end else begin
            data_readRegB = r_mem[ctrl_readRegB];
        end

        data_tap = r_mem[TAP_IDX];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Directed bench for regfile_mp (DATA_W=32, ADDR_W=5, TAP_REG=10,
// ZERO_REG0=1). Inputs change 1 time unit after a rising edge; outputs are
// sampled a further 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clock;
    logic              ctrl_reset;
    logic              ctrl_we0;
    logic [ADDR_W-1:0] ctrl_waddr0;
    logic [DATA_W-1:0] data_w0;
    logic              ctrl_we1;
    logic [ADDR_W-1:0] ctrl_waddr1;
    logic [DATA_W-1:0] data_w1;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;
    logic [DATA_W-1:0] data_tap;
    logic              ctrl_clear;
    logic              clear_busy;
    logic              wr_dropped;
    logic              dbg_state;

    int errors;
    int checks;
    int busy_cycles;

    regfile_mp #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .TAP_REG   (10),
        .ZERO_REG0 (1)
    ) dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .ctrl_we0      (ctrl_we0),
        .ctrl_waddr0   (ctrl_waddr0),
        .data_w0       (data_w0),
        .ctrl_we1      (ctrl_we1),
        .ctrl_waddr1   (ctrl_waddr1),
        .data_w1       (data_w1),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .data_readRegA (data_readRegA),
        .data_readRegB (data_readRegB),
        .data_tap      (data_tap),
        .ctrl_clear    (ctrl_clear),
        .clear_busy    (clear_busy),
        .wr_dropped    (wr_dropped),
        .dbg_state     (dbg_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge, leaving 1 unit of settle time.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        busy_cycles   = 0;
        ctrl_reset    = 1'b0;
        ctrl_we0      = 1'b1;
        ctrl_waddr0   = 5'd5;
        data_w0       = 32'hDEADBEEF;
        ctrl_we1      = 1'b0;
        ctrl_waddr1   = '0;
        data_w1       = '0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        ctrl_clear    = 1'b0;

        // ---- Reset held two cycles with a write enabled ----
        tick();
        tick();
        ctrl_reset    = 1'b1;
        ctrl_we0      = 1'b0;
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd10;
        #1;
        check("rst_readA_r5", data_readRegA, 32'h0);
        check("rst_readB_r10", data_readRegB, 32'h0);
        check("rst_wr_dropped", {31'b0, wr_dropped}, 32'h0);
        check("rst_clear_busy", {31'b0, clear_busy}, 32'h0);
        check("rst_tap", data_tap, 32'h0);

        // ---- Dual-write conflict and bypass ----
        ctrl_we0      = 1'b1;
        ctrl_waddr0   = 5'd7;
        data_w0       = 32'h11111111;
        ctrl_we1      = 1'b1;
        ctrl_waddr1   = 5'd7;
        data_w1       = 32'h22222222;
        ctrl_readRegA = 5'd7;
        #1;
        check("conflict_bypass_A", data_readRegA, 32'h22222222);
        tick();
        ctrl_we0 = 1'b0;
        ctrl_we1 = 1'b0;
        #1;
        check("conflict_stored_A", data_readRegA, 32'h22222222);

        // Port 0 alone bypasses when port 1 targets another address
        ctrl_we0      = 1'b1;
        ctrl_waddr0   = 5'd3;
        data_w0       = 32'h33333333;
        ctrl_readRegB = 5'd3;
        #1;
        check("bypass_port0_B", data_readRegB, 32'h33333333);
        tick();
        ctrl_we0 = 1'b0;
        #1;
        check("port0_stored_B", data_readRegB, 32'h33333333);

        // ---- Zero register ----
        ctrl_we1      = 1'b1;
        ctrl_waddr1   = 5'd0;
        data_w1       = 32'hFFFFFFFF;
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        #1;
        check("zero_A_same", data_readRegA, 32'h0);
        check("zero_B_same", data_readRegB, 32'h0);
        tick();
        ctrl_we1 = 1'b0;
        #1;
        check("zero_A_next", data_readRegA, 32'h0);
        check("zero_B_next", data_readRegB, 32'h0);

        // ---- Tap ----
        check("tap_before", data_tap, 32'h0);
        ctrl_we0      = 1'b1;
        ctrl_waddr0   = 5'd10;
        data_w0       = 32'h00000ABC;
        ctrl_readRegA = 5'd10;
        #1;
        check("tap_bypass_A", data_readRegA, 32'h00000ABC);
        check("tap_no_bypass", data_tap, 32'h0);
        tick();
        ctrl_we0 = 1'b0;
        #1;
        check("tap_after", data_tap, 32'h00000ABC);

        // ---- Preload registers 1..31 with their index ----
        for (int i = 1; i < DEPTH; i++) begin
            ctrl_we0    = 1'b1;
            ctrl_waddr0 = ADDR_W'(i);
            data_w0     = DATA_W'(i);
            tick();
        end
        ctrl_we0      = 1'b0;
        ctrl_readRegA = 5'd31;
        ctrl_readRegB = 5'd1;
        #1;
        check("preload_r31", data_readRegA, 32'd31);
        check("preload_r1", data_readRegB, 32'd1);
        check("preload_tap", data_tap, 32'd10);

        // ---- Clear sweep ----
        ctrl_clear = 1'b1;
        #1;
        check("clear_pulse_busy", {31'b0, clear_busy}, 32'h0);
        tick();
        ctrl_clear = 1'b0;
        // cyc k is the cycle in which register k is cleared at the closing edge
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 5) begin
                ctrl_we0      = 1'b1;
                ctrl_waddr0   = 5'd31;
                data_w0       = 32'h55;
                ctrl_readRegA = 5'd31;
                ctrl_readRegB = 5'd3;
            end
            if (cyc == 6) ctrl_we0 = 1'b0;
            if (cyc == 10) ctrl_clear = 1'b1;
            if (cyc == 11) ctrl_clear = 1'b0;
            #1;
            if (clear_busy) busy_cycles++;
            if (cyc == 0) check("sweep_busy_c0", {31'b0, clear_busy}, 32'h1);
            if (cyc == 5) begin
                check("sweep_no_bypass", data_readRegA, 32'd31);
                check("sweep_partial_r3", data_readRegB, 32'h0);
                check("sweep_drop_c5", {31'b0, wr_dropped}, 32'h0);
            end
            if (cyc == 6) check("sweep_drop_c6", {31'b0, wr_dropped}, 32'h1);
            if (cyc == 7) check("sweep_drop_c7", {31'b0, wr_dropped}, 32'h0);
            if (cyc == 31) check("sweep_busy_c31", {31'b0, clear_busy}, 32'h1);
            if (cyc == 32) check("sweep_busy_c32", {31'b0, clear_busy}, 32'h0);
            tick();
        end
        check("sweep_busy_cycles", DATA_W'(busy_cycles), 32'd32);
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_readRegA = ADDR_W'(i);
            #1;
            check($sformatf("post_sweep_r%0d", i), data_readRegA, 32'h0);
        end
        check("post_sweep_tap", data_tap, 32'h0);

        // ---- Reset mid-sweep ----
        ctrl_we0    = 1'b1;
        ctrl_waddr0 = 5'd20;
        data_w0     = 32'h1234;
        ctrl_we1    = 1'b1;
        ctrl_waddr1 = 5'd31;
        data_w1     = 32'h99;
        tick();
        ctrl_we0      = 1'b0;
        ctrl_we1      = 1'b0;
        ctrl_readRegA = 5'd20;
        ctrl_readRegB = 5'd31;
        #1;
        check("pre_rst_r20", data_readRegA, 32'h1234);
        check("pre_rst_r31", data_readRegB, 32'h99);
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("midsweep_busy", {31'b0, clear_busy}, 32'h1);
        ctrl_reset  = 1'b0;
        ctrl_we1    = 1'b1;
        ctrl_waddr1 = 5'd20;
        data_w1     = 32'hABCD;
        tick();
        ctrl_reset = 1'b1;
        ctrl_we1   = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, clear_busy}, 32'h0);
        check("rst_mid_r20", data_readRegA, 32'h0);
        check("rst_mid_r31", data_readRegB, 32'h0);
        ctrl_we0      = 1'b1;
        ctrl_waddr0   = 5'd12;
        data_w0       = 32'hCAFE;
        ctrl_readRegA = 5'd12;
        tick();
        ctrl_we0 = 1'b0;
        #1;
        check("post_rst_write", data_readRegA, 32'hCAFE);
        check("post_rst_dropped", {31'b0, wr_dropped}, 32'h0);
        check("post_rst_busy", {31'b0, clear_busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
